// File: rtl/full_adder_using_half_subtractors_pkg.sv
// full_adder_using_half_subtractors_pkg: shared arithmetic constants
package full_adder_using_half_subtractors_pkg;
    localparam int WIDTH_DEFAULT = 1;
endpackage

// File: rtl/half_subtractor.sv
// half_subtractor: one-bit x - y cell producing difference and borrow-out
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic diff,
    output logic bout
);
    assign diff = x ^ y;
    assign bout = ~x & y;
endmodule

// File: rtl/full_adder_using_half_subtractors.sv
// full_adder_using_half_subtractors: ripple adder built from half-subtractors,
// with a combinational result and an enabled, async-cleared registered copy
module full_adder_using_half_subtractors
    import full_adder_using_half_subtractors_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             en,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] d1, gen, prop;
    logic [WIDTH-1:0] unused_b1, unused_d3, unused_d4;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    assign c[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_slice
            half_subtractor u_hs1 (.x(A[i]),  .y(B[i]), .diff(d1[i]),        .bout(unused_b1[i]));
            half_subtractor u_hs2 (.x(d1[i]), .y(c[i]), .diff(Sum[i]),       .bout());
            // inverting x turns the borrow ~x&y into an AND of the true inputs
            half_subtractor u_hs3 (.x(~A[i]), .y(B[i]), .diff(unused_d3[i]), .bout(gen[i]));
            half_subtractor u_hs4 (.x(~c[i]), .y(d1[i]), .diff(unused_d4[i]), .bout(prop[i]));
            assign c[i+1] = gen[i] | prop[i];
        end
    endgenerate

    assign Cout = c[WIDTH];

    always_comb begin
        sum_d  = en ? Sum  : sum_q;
        cout_d = en ? Cout : cout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum_q  = sum_q;
    assign Cout_q = cout_q;
endmodule

// File: tb/tb_full_adder_using_half_subtractors.sv
// tb_full_adder_using_half_subtractors: checks 1/4/8-bit instances against
// plain integer addition and a one-entry register model
module tb_full_adder_using_half_subtractors;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       cin = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, s1, sq1;
    logic [3:0] a4 = '0, b4 = '0, s4, sq4;
    logic [7:0] a8 = '0, b8 = '0, s8, sq8;
    logic       co1, coq1, co4, coq4, co8, coq8;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    full_adder_using_half_subtractors #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin), .en(en),
        .Sum(s1), .Cout(co1), .Sum_q(sq1), .Cout_q(coq1));
    full_adder_using_half_subtractors #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin), .en(en),
        .Sum(s4), .Cout(co4), .Sum_q(sq4), .Cout_q(coq4));
    full_adder_using_half_subtractors #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin), .en(en),
        .Sum(s8), .Cout(co8), .Sum_q(sq8), .Cout_q(coq8));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [8:0] m;
        logic [8:0] exp_q;
        logic [8:0] exp_next;
        // reset held with all-ones inputs: registers stay clear, comb path live
        a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_q", 64'({coq1, sq1}), 64'd0);
            check("rst_comb", 64'({co1, s1}), 64'h3);
        end
        // exhaustive 1-bit truth table
        for (int v = 0; v < 8; v++) begin
            {a1, b1, cin} = 3'(v);
            #1;
            m = 9'(a1) + 9'(b1) + 9'(cin);
            check($sformatf("tt%0d", v), 64'({co1, s1}), 64'(m[1:0]));
        end
        // 4-bit ripple boundaries
        a4 = 4'hF; b4 = 4'h1; cin = 1'b0; #1;
        check("w4_f1", 64'({co4, s4}), 64'h10);
        a4 = 4'hA; b4 = 4'h5; cin = 1'b1; #1;
        check("w4_a5", 64'({co4, s4}), 64'h10);
        a4 = 4'h3; b4 = 4'h4; cin = 1'b0; #1;
        check("w4_34", 64'({co4, s4}), 64'h07);
        // leave reset away from the clock edge, then capture
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; a1 = 1'b1; b1 = 1'b0; cin = 1'b1;
        @(posedge clk); #1;
        check("cap", 64'({coq1, sq1}), 64'h2);
        @(negedge clk);
        en = 1'b0; a1 = 1'b0; b1 = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        check("hold", 64'({coq1, sq1}), 64'h2);
        // async clear between edges
        @(negedge clk);
        en = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        check("load11", 64'({coq1, sq1}), 64'h3);
        #1 rst_n = 1'b0;
        #1;
        check("async_clr", 64'({coq1, sq1}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        // random 8-bit: comb vs integer sum, register vs previous-cycle model
        exp_q = '0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom);
            en = (n == 0) ? 1'b1 : 1'($urandom);
            #1;
            m = 9'(a8) + 9'(b8) + 9'(cin);
            check("r8_comb", 64'({co8, s8}), 64'(m));
            exp_next = en ? m : exp_q;
            @(posedge clk); #1;
            check("r8_reg", 64'({coq8, sq8}), 64'(exp_next));
            exp_q = exp_next;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
